// File: rtl/i2c_rx_regfile.sv
// Write-only I2C slave byte decoder with an auto-incrementing register file.
// Optional write-protect lock on regs[0] bit 0 is enabled by I2C_RX_REGFILE_WP_EN.

module i2c_rx_regfile_chk (
   input logic clk,
   input logic rst,
   input logic data_rdy,
   input logic ack_en,
   input logic ack
);

   // ack is registered, so a low ack must trace back to a low data_rdy one edge earlier
   ack_only_in_window: assert property (@(posedge clk) disable iff (rst)
      !ack |-> $past(!data_rdy));

   ack_in_receiver_window: cover property (@(posedge clk) disable iff (rst)
      !ack && !ack_en);

endmodule

module i2c_rx_regfile #(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         NUM_REGS = 16,
   parameter int         ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        data,
   input  logic              data_rdy,
   input  logic              ack_en,
   output logic              ack,
   input  logic              bus_stop,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data
);

   typedef enum logic [1:0] {
      S_ADDR   = 2'd0,
      S_PTR    = 2'd1,
      S_DATA   = 2'd2,
      S_IGNORE = 2'd3
   } state_t;

   localparam logic [8:0]        NUM_REGS_B = 9'(NUM_REGS);
   localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [7:0]        regs_q [NUM_REGS];
   logic              ack_q;
   logic              data_rdy_q;
   logic              wr_valid_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic              byte_evt_s;
   logic              accept_s;
   logic              commit_s;
   logic              wp_block_s;

   assign byte_evt_s = data_rdy_q & ~data_rdy;

`ifdef I2C_RX_REGFILE_WP_EN
   assign wp_block_s = regs_q[0][0] & (ptr_q != PTR_ZERO);
`else
   assign wp_block_s = 1'b0;
`endif

   // Decision for the current byte, applied by the register block only on a byte event
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      accept_s = 1'b0;
      commit_s = 1'b0;
      case (state_q)
         S_ADDR: begin
            if ((data[7:1] == DEV_ADDR) && !data[0]) begin
               accept_s = 1'b1;
               state_d  = S_PTR;
            end else begin
               state_d  = S_IGNORE;
            end
         end
         S_PTR: begin
            if ({1'b0, data} < NUM_REGS_B) begin
               accept_s = 1'b1;
               ptr_d    = data[ADDR_W-1:0];
               state_d  = S_DATA;
            end else begin
               state_d  = S_IGNORE;
            end
         end
         S_DATA: begin
            if (!wp_block_s) begin
               accept_s = 1'b1;
               commit_s = 1'b1;
            end else begin
               accept_s = 1'b0;
               commit_s = 1'b0;
            end
            // A locked write still advances the pointer
            ptr_d = (ptr_q == LAST_PTR) ? PTR_ZERO : ptr_q + ADDR_W'(1);
         end
         S_IGNORE: begin
            state_d = S_IGNORE;
         end
         default: begin
            state_d = S_ADDR;
         end
      endcase
   end

   // FSM, ack/write outputs and register file; STOP overrides a coincident byte
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_ADDR;
         ptr_q      <= PTR_ZERO;
         ack_q      <= 1'b1;
         data_rdy_q <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= PTR_ZERO;
         wr_data_q  <= 8'h00;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         data_rdy_q <= data_rdy;
         wr_valid_q <= 1'b0;
         if (bus_stop) begin
            state_q <= S_ADDR;
            ack_q   <= 1'b1;
         end else if (byte_evt_s) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ~accept_s;
            if (commit_s) begin
               regs_q[ptr_q] <= data;
               wr_valid_q    <= 1'b1;
               wr_addr_q     <= ptr_q;
               wr_data_q     <= data;
            end
         end else if (data_rdy) begin
            ack_q <= 1'b1;
         end
      end
   end

   // Combinational read port with out-of-range guard for non-power-of-two sizes
   always_comb begin
      if ({1'b0, rd_addr} < NUM_REGS_A) begin
         rd_data = regs_q[rd_addr];
      end else begin
         rd_data = 8'h00;
      end
   end

   assign ack      = ack_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

   i2c_rx_regfile_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .data_rdy (data_rdy),
      .ack_en   (ack_en),
      .ack      (ack)
   );

endmodule

// File: tb/tb_i2c_rx_regfile.sv
// Bench for i2c_rx_regfile: directed vector table, corner sequences and randomized
// byte streams checked against a transaction-level model.

module tb_i2c_rx_regfile;

   localparam int NREGS = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    data;
   logic          data_rdy;
   logic          ack_en;
   logic          ack;
   logic          bus_stop;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [NREGS];
   int         m_cnt;
   bit         m_bad;
   int         m_ptr;

   typedef struct {
      int         kind;
      logic [7:0] d;
      logic       e_ack;
      logic       e_wr;
      int         e_addr;
   } vec_t;

   vec_t tbl[$];

   i2c_rx_regfile #(.DEV_ADDR(7'h42), .NUM_REGS(NREGS)) dut (
      .clk      (clk),
      .rst      (rst),
      .data     (data),
      .data_rdy (data_rdy),
      .ack_en   (ack_en),
      .ack      (ack),
      .bus_stop (bus_stop),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
      m_cnt = 0;
      m_bad = 1'b0;
      m_ptr = 0;
   endfunction

   // Transaction view: byte 0 is the address, byte 1 the pointer, the rest data
   task automatic model_byte(input logic [7:0] b, input bit stop,
                             output logic e_ack, output logic e_wr, output int e_addr);
      bit locked;
      e_ack  = 1'b1;
      e_wr   = 1'b0;
      e_addr = 0;
      locked = 1'b0;
      if (stop) begin
         m_cnt = 0;
         m_bad = 1'b0;
      end else begin
         if (m_bad) begin
            e_ack = 1'b1;
         end else if (m_cnt == 0) begin
            if (b[7:1] == 7'h42 && b[0] == 1'b0) e_ack = 1'b0;
            else m_bad = 1'b1;
         end else if (m_cnt == 1) begin
            if (int'(b) < NREGS) begin
               e_ack = 1'b0;
               m_ptr = int'(b);
            end else begin
               m_bad = 1'b1;
            end
         end else begin
`ifdef I2C_RX_REGFILE_WP_EN
            locked = mem[0][0] && (m_ptr != 0);
`endif
            if (!locked) begin
               mem[m_ptr] = b;
               e_wr   = 1'b1;
               e_addr = m_ptr;
               e_ack  = 1'b0;
            end
            m_ptr = (m_ptr + 1) % NREGS;
         end
         if (m_cnt < 2) m_cnt++;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b, input bit stop, input logic e_ack,
                             input logic e_wr, input int e_addr, input string tag);
      @(negedge clk);
      data     = b;
      data_rdy = 1'b0;
      ack_en   = 1'b0;
      bus_stop = stop;
      rd_addr  = AW'(e_addr);
      @(negedge clk);
      bus_stop = 1'b0;
      check({tag, " ack"}, 32'(ack), 32'(e_ack));
      check({tag, " wr_valid"}, 32'(wr_valid), 32'(e_wr));
      if (e_wr) begin
         check({tag, " wr_addr"}, 32'(wr_addr), 32'(e_addr));
         check({tag, " wr_data"}, 32'(wr_data), 32'(b));
         check({tag, " rd_data"}, 32'(rd_data), 32'(b));
      end
      @(negedge clk);
      check({tag, " ack_hold"}, 32'(ack), 32'(e_ack));
      check({tag, " wr_pulse_end"}, 32'(wr_valid), 32'd0);
      data_rdy = 1'b1;
      ack_en   = 1'b1;
      data     = 8'($urandom);
      @(negedge clk);
      check({tag, " ack_release"}, 32'(ack), 32'd1);
   endtask

   task automatic stop_pulse(input string tag);
      logic a, w;
      int   ad;
      @(negedge clk);
      bus_stop = 1'b1;
      @(negedge clk);
      bus_stop = 1'b0;
      model_byte(8'h00, 1'b1, a, w, ad);
      check({tag, " stop_ack"}, 32'(ack), 32'd1);
   endtask

   task automatic model_drive(input logic [7:0] b, input bit stop, input string tag);
      logic a, w;
      int   ad;
      model_byte(b, stop, a, w, ad);
      drive_byte(b, stop, a, w, ad, tag);
   endtask

   task automatic read_reg(input int idx, input logic [7:0] exp, input string tag);
      @(negedge clk);
      rd_addr = AW'(idx);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < NREGS; i++) begin
         read_reg(i, mem[i], $sformatf("%s reg%0d", tag, i));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      data_rdy = 1'b1;
      ack_en   = 1'b1;
      bus_stop = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic vec_t mk(input int k, input logic [7:0] d, input logic a,
                               input logic w, input int ad);
      vec_t v;
      v.kind   = k;
      v.d      = d;
      v.e_ack  = a;
      v.e_wr   = w;
      v.e_addr = ad;
      return v;
   endfunction

   initial begin
      // kind: 0 = byte, 1 = standalone STOP, 2 = byte coincident with STOP
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h03, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'hA5, 1'b0, 1'b1, 3));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h86, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h85, 1'b1, 1'b0, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h0F, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h11, 1'b0, 1'b1, 15));
      tbl.push_back(mk(0, 8'h22, 1'b0, 1'b1, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h10, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h55, 1'b1, 1'b0, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h05, 1'b0, 1'b0, 0));
      tbl.push_back(mk(2, 8'h77, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h01, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h3C, 1'b0, 1'b1, 1));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));

      rst      = 1'b1;
      data     = 8'h00;
      data_rdy = 1'b1;
      ack_en   = 1'b1;
      bus_stop = 1'b0;
      rd_addr  = 4'd0;
      repeat (3) @(negedge clk);
      check("reset ack", 32'(ack), 32'd1);
      check("reset wr_valid", 32'(wr_valid), 32'd0);
      check("reset wr_addr", 32'(wr_addr), 32'd0);
      check("reset wr_data", 32'(wr_data), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      rst = 1'b0;
      model_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         logic a, w;
         int   ad;
         if (tbl[i].kind == 1) begin
            stop_pulse($sformatf("vec%0d", i));
         end else begin
            model_byte(tbl[i].d, tbl[i].kind == 2, a, w, ad);
            drive_byte(tbl[i].d, tbl[i].kind == 2, tbl[i].e_ack, tbl[i].e_wr,
                       tbl[i].e_addr, $sformatf("vec%0d", i));
         end
      end
      read_reg(3, 8'hA5, "tbl reg3");
      read_reg(15, 8'h11, "tbl reg15 wrap");
      read_reg(0, 8'h22, "tbl reg0 wrap");
      read_reg(5, 8'h00, "tbl reg5 untouched");
      read_reg(1, 8'h3C, "tbl reg1 after stop-drop");
      sweep("tbl");

      // Reset asserted in the cycle of a data byte event discards everything
      model_drive(8'h84, 1'b0, "rstseq addr");
      model_drive(8'h02, 1'b0, "rstseq ptr");
      @(negedge clk);
      data     = 8'h3C;
      data_rdy = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("rstseq ack", 32'(ack), 32'd1);
      check("rstseq wr_valid", 32'(wr_valid), 32'd0);
      rst      = 1'b0;
      data_rdy = 1'b1;
      model_reset();
      read_reg(2, 8'h00, "rstseq reg2");
      read_reg(3, 8'h00, "rstseq reg3 cleared");
      model_drive(8'h84, 1'b0, "rstseq readdr");

      for (int n = 0; n < 400; n++) begin
         int         r;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (m_cnt == 0) b = ($urandom_range(0, 9) < 7) ? 8'h84 : 8'($urandom);
         else if (m_cnt == 1) b = 8'($urandom_range(0, 19));
         else b = 8'($urandom);
         if (r < 8) stop_pulse($sformatf("rnd%0d", n));
         else model_drive(b, r < 12, $sformatf("rnd%0d", n));
         if (n % 100 == 99) sweep($sformatf("rnd%0d", n));
      end

`ifdef I2C_RX_REGFILE_WP_EN
      do_reset();
      tbl.delete();
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h00, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h01, 1'b0, 1'b1, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h02, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h99, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h98, 1'b1, 1'b0, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h00, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h00, 1'b0, 1'b1, 0));
      tbl.push_back(mk(1, 8'h00, 1'b1, 1'b0, 0));
      tbl.push_back(mk(0, 8'h84, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h02, 1'b0, 1'b0, 0));
      tbl.push_back(mk(0, 8'h99, 1'b0, 1'b1, 2));
      for (int i = 0; i < tbl.size(); i++) begin
         logic a, w;
         int   ad;
         if (tbl[i].kind == 1) begin
            stop_pulse($sformatf("wp%0d", i));
         end else begin
            model_byte(tbl[i].d, 1'b0, a, w, ad);
            drive_byte(tbl[i].d, 1'b0, tbl[i].e_ack, tbl[i].e_wr, tbl[i].e_addr,
                       $sformatf("wp%0d", i));
         end
         if (i == 7) begin
            read_reg(2, 8'h00, "wp reg2 locked");
            read_reg(3, 8'h00, "wp reg3 locked");
         end
      end
      read_reg(2, 8'h99, "wp reg2 unlocked");
      read_reg(0, 8'h00, "wp reg0 cleared");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
